// File: rtl/mem_scan_pkg.sv
// Shared types for the memory-scan viewer: FSM states, step mode and the
// address increment between consecutive words.
package mem_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ADV
  } state_e;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  localparam int unsigned WORD_STEP = 4;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Any bounce back to the accepted level restarts the stability window.
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        stable <= sync_p1;
        cnt    <= '0;
        press  <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_scan_viewer.sv
// Memory-scan debug block: steps through a window of RAM words, one read per
// step, and shows a bit field of each returned word on the LEDs.
module mem_scan_viewer
  import mem_scan_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned SCAN_WORDS  = 4,
  parameter int unsigned FIELD_LSB   = 4,
  parameter int unsigned LED_WIDTH   = 3,
  parameter int unsigned TICK_DIV    = 8388608,
  parameter int unsigned HB_PERIOD   = 32000000,
  parameter int unsigned DEB_CYCLES  = 65536,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  btn_step,
  input  logic                  btn_mode,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [LED_WIDTH-1:0]  leds,
  output logic                  err_led,
  output logic                  mode_led,
  output logic                  hb_led,
  output logic                  busy
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int HB_W   = $clog2(HB_PERIOD);
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(BASE_ADDR + WORD_STEP * (SCAN_WORDS - 1));
  localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(WORD_STEP);

  logic              step_press;
  logic              mode_press;
  state_e            state;
  mode_e             mode;
  logic              mode_pend;
  logic [TICK_W-1:0] tick_cnt;
  logic [HB_W-1:0]   hb_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              tick_wrap;
  logic              step_evt;
  logic              unused_rdata;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_step),
    .press   (step_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_mode),
    .press   (mode_press)
  );

  assign tick_wrap    = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign step_evt     = (mode == MODE_AUTO) ? tick_wrap : step_press;
  assign hb_led       = (hb_cnt < HB_W'(HB_PERIOD / 2));
  assign mode_led     = (mode == MODE_AUTO);
  assign unused_rdata = ^mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      hb_cnt   <= '0;
    end else begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
      hb_cnt   <= (hb_cnt == HB_W'(HB_PERIOD - 1)) ? '0 : hb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      mode      <= MODE_AUTO;
      mode_pend <= 1'b0;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= BASE_A;
      leds      <= '0;
      err_led   <= 1'b0;
      to_cnt    <= '0;
    end else begin
      // Mode presses are parked until the FSM is idle so a read is never cut short.
      mode_pend <= mode_pend ^ mode_press;
      case (state)
        IDLE: begin
          mode_pend <= 1'b0;
          if (mode_pend ^ mode_press)
            mode <= (mode == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
          if (step_evt) begin
            state   <= REQ;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            to_cnt  <= '0;
          end
        end
        REQ: begin
          state  <= WAIT;
          to_cnt <= to_cnt + 1'b1;
        end
        WAIT: begin
          if (mem_ack) begin
            leds    <= mem_rdata[FIELD_LSB +: LED_WIDTH];
            err_led <= 1'b0;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state   <= ADV;
          end else if (to_cnt == TO_W'(ACK_TIMEOUT)) begin
            leds    <= '1;
            err_led <= 1'b1;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state   <= ADV;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ADV: begin
          mem_addr <= (mem_addr == LAST_A) ? BASE_A : mem_addr + STEP_A;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_scan_viewer.sv
// Directed bench for mem_scan_viewer with a small request/ack RAM model.
module tb_mem_scan_viewer;

  localparam logic [31:0] BASE = 32'h100;

  logic        clk;
  logic        reset_n;
  logic        btn_step;
  logic        btn_mode;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [2:0]  leds;
  logic        err_led;
  logic        mode_led;
  logic        hb_led;
  logic        busy;

  int          vecs;
  int          errs;
  int          req_cnt;
  int          req_base;
  int          base;
  logic        req_q = 1'b0;

  logic [31:0] ram [4];
  logic        ram_en;
  int          ack_lat;
  int          ram_cnt;
  int          ram_idx;
  logic        ram_ack;
  logic [31:0] ram_rd;
  logic        force_ack;
  logic [31:0] force_data;

  mem_scan_viewer #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .BASE_ADDR   (32'h100),
    .SCAN_WORDS  (4),
    .FIELD_LSB   (4),
    .LED_WIDTH   (3),
    .TICK_DIV    (8),
    .HB_PERIOD   (10),
    .DEB_CYCLES  (4),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_step  (btn_step),
    .btn_mode  (btn_mode),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .leds      (leds),
    .err_led   (err_led),
    .mode_led  (mode_led),
    .hb_led    (hb_led),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack   = ram_ack | force_ack;
  assign mem_rdata = force_ack ? force_data : ram_rd;

  // RAM: with latency 0 the ack lands in the first WAIT cycle.
  always @(negedge clk) begin
    if (mem_req && ram_en) begin
      ram_cnt = ram_cnt + 1;
      ram_idx = int'((mem_addr - BASE) >> 2) % 4;
      ram_rd  = ram[ram_idx];
      ram_ack = (ram_cnt == ack_lat + 2);
    end else begin
      ram_cnt = 0;
      ram_ack = 1'b0;
    end
  end

  always @(posedge clk) begin
    req_q <= mem_req;
    if (mem_req && !req_q) req_cnt <= req_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int lim);
    int n = 0;
    while (mem_req !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_req", {31'b0, mem_req}, 32'd1);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_hb(input logic val, input int lim);
    int n = 0;
    while (hb_led !== val && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_hb", {31'b0, hb_led}, {31'b0, val});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs = 0; errs = 0; req_cnt = 0;
    reset_n = 1'b0; btn_step = 1'b0; btn_mode = 1'b0;
    force_ack = 1'b0; force_data = '0;
    ram_en = 1'b1; ack_lat = 0; ram_cnt = 0; ram_ack = 1'b0; ram_rd = '0;
    ram[0] = 32'h10; ram[1] = 32'h20; ram[2] = 32'h30; ram[3] = 32'h40;
    step(3);

    // Reset values
    chk("rst_req",   {31'b0, mem_req},  32'd0);
    chk("rst_addr",  mem_addr,          BASE);
    chk("rst_leds",  {29'b0, leds},     32'd0);
    chk("rst_err",   {31'b0, err_led},  32'd0);
    chk("rst_mode",  {31'b0, mode_led}, 32'd1);
    chk("rst_hb",    {31'b0, hb_led},   32'd1);
    chk("rst_busy",  {31'b0, busy},     32'd0);
    reset_n = 1'b1;

    // AUTO scan, zero-wait RAM, wraps after four words
    for (int i = 0; i < 5; i++) begin
      wait_req(20);
      chk("auto_addr", mem_addr, BASE + 32'(4 * (i % 4)));
      step(2);
      chk("auto_leds", {29'b0, leds}, 32'((i % 4) + 1));
      chk("auto_req_drop", {31'b0, mem_req}, 32'd0);
    end
    req_base = 0;

    // Switch to MANUAL: no reads while idle
    btn_mode = 1'b1; step(8); btn_mode = 1'b0; step(20);
    chk("manual_mode", {31'b0, mode_led}, 32'd0);
    wait_idle(20);
    base = req_cnt;
    step(40);
    chk("manual_no_reads", 32'(req_cnt - base), 32'd0);

    // One long step press -> exactly one read
    base = req_cnt;
    btn_step = 1'b1;
    wait_req(20);
    chk("manual_addr", mem_addr, BASE + 32'(4 * ((base - req_base) % 4)));
    step(2);
    chk("manual_leds", {29'b0, leds}, 32'(((base - req_base) % 4) + 1));
    step(3); btn_step = 1'b0;
    step(30);
    chk("manual_one_read", 32'(req_cnt - base), 32'd1);

    // Press shorter than the debounce window -> nothing
    base = req_cnt;
    btn_step = 1'b1; step(2); btn_step = 1'b0;
    step(30);
    chk("short_press", 32'(req_cnt - base), 32'd0);

    // Ack never arrives: timeout after 16 cycles
    ram_en = 1'b0;
    btn_step = 1'b1;
    wait_req(20);
    btn_step = 1'b0;
    step(15);
    chk("to_err_early", {31'b0, err_led}, 32'd0);
    chk("to_busy", {31'b0, busy}, 32'd1);
    step(1);
    chk("to_err", {31'b0, err_led}, 32'd1);
    chk("to_leds", {29'b0, leds}, 32'd7);
    chk("to_req_drop", {31'b0, mem_req}, 32'd0);
    step(10);
    ram[0] = 32'h50; ram[1] = 32'h50; ram[2] = 32'h50; ram[3] = 32'h50;
    ram_en = 1'b1;
    btn_step = 1'b1;
    wait_req(20);
    step(2); btn_step = 1'b0;
    chk("after_to_leds", {29'b0, leds}, 32'd5);
    chk("after_to_err", {31'b0, err_led}, 32'd0);
    ram[0] = 32'h10; ram[1] = 32'h20; ram[2] = 32'h30; ram[3] = 32'h40;
    step(10);

    // Reset during WAIT; a late ack is ignored
    ram_en = 1'b0;
    btn_step = 1'b1;
    wait_req(20);
    btn_step = 1'b0;
    step(3);
    reset_n = 1'b0;
    step(1);
    chk("wrst_req", {31'b0, mem_req}, 32'd0);
    chk("wrst_addr", mem_addr, BASE);
    chk("wrst_busy", {31'b0, busy}, 32'd0);
    chk("wrst_leds", {29'b0, leds}, 32'd0);
    chk("wrst_mode", {31'b0, mode_led}, 32'd1);
    reset_n = 1'b1;
    force_data = 32'h70; force_ack = 1'b1;
    step(2);
    force_ack = 1'b0;
    chk("late_ack_leds", {29'b0, leds}, 32'd0);
    chk("late_ack_err", {31'b0, err_led}, 32'd0);
    ram_en = 1'b1; ack_lat = 0;

    // Back to MANUAL, then a step press while a slow read is in flight
    btn_mode = 1'b1; step(8); btn_mode = 1'b0; step(20);
    chk("manual2_mode", {31'b0, mode_led}, 32'd0);
    wait_idle(20);
    step(10);
    ack_lat = 12;
    base = req_cnt;
    btn_step = 1'b1; step(6); btn_step = 1'b0;
    wait_req(10);
    step(5);
    btn_step = 1'b1; step(6); btn_step = 1'b0;
    step(30);
    chk("busy_drop_one_read", 32'(req_cnt - base), 32'd1);

    // Mode press mid-read takes effect only once idle
    btn_step = 1'b1; step(6); btn_step = 1'b0;
    wait_req(10);
    btn_mode = 1'b1; step(6); btn_mode = 1'b0;
    step(2);
    chk("mode_hold_mid_read", {31'b0, mode_led}, 32'd0);
    chk("mode_mid_busy", {31'b0, busy}, 32'd1);
    wait_idle(30);
    step(2);
    chk("mode_after_read", {31'b0, mode_led}, 32'd1);

    // Heartbeat: 5 low, 5 high
    wait_hb(1'b1, 20);
    wait_hb(1'b0, 20);
    for (int i = 0; i < 10; i++) begin
      chk("hb_pattern", {31'b0, hb_led}, (i < 5) ? 32'd0 : 32'd1);
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
